// File: rtl/thermal_guard_pkg.sv
// ---------------------------------------------------------------------------
// thermal_guard_pkg
// Shared definitions for the sysmon thermal guard: supervisor state encoding,
// register window offsets, control-register bit positions, reset defaults
// and small arithmetic helpers used by the escalation logic.
// ---------------------------------------------------------------------------
package thermal_guard_pkg;

   typedef enum logic [1:0] {
      ST_NORMAL = 2'd0,
      ST_WARN   = 2'd1,
      ST_ALARM  = 2'd2
   } tg_state_e;

   // Byte offsets inside the 4-word register window
   localparam logic [31:0] OFF_STATUS = 32'h0000_0000;
   localparam logic [31:0] OFF_THRESH = 32'h0000_0004;
   localparam logic [31:0] OFF_HYST   = 32'h0000_0008;
   localparam logic [31:0] OFF_CTRL   = 32'h0000_000C;

   // Control-register write bits
   localparam int unsigned CLR_BIT   = 0;
   localparam int unsigned MMRST_BIT = 1;

   // Reset defaults (raw system-monitor LSBs)
   localparam logic [9:0] DEF_WARN_TH  = 10'h2C3;
   localparam logic [9:0] DEF_ALARM_TH = 10'h2EC;
   localparam logic [5:0] DEF_HYST     = 6'd8;

   // Release level of a threshold: thr - hyst, clamped at zero
   function automatic logic [9:0] release_level(input logic [9:0] thr,
                                                input logic [5:0] hyst);
      logic [9:0] hyst_ext;
      hyst_ext = {4'd0, hyst};
      if (thr > hyst_ext) begin
         return thr - hyst_ext;
      end else begin
         return 10'd0;
      end
   endfunction

   // Saturating increment of the 4-bit debounce counter
   function automatic logic [3:0] sat_inc4(input logic [3:0] v);
      if (v == 4'hF) begin
         return 4'hF;
      end else begin
         return v + 4'd1;
      end
   endfunction

endpackage

// File: rtl/thermal_sample_timer.sv
// ---------------------------------------------------------------------------
// thermal_sample_timer
// Brings the asynchronous system-monitor temperature into the PicoClk domain
// and produces one captured sample per divider period. The raw value passes
// a two-flop synchroniser plus a third compare stage; a pending request is
// only served once two consecutive synchronised values agree, so a code that
// is mid-transition is never captured.
//
// Ports:
//   clk        in   sampling clock
//   rst_n      in   asynchronous active-low reset
//   temp[9:0]  in   raw temperature (asynchronous)
//   sample_vld out  one-cycle pulse, last is fresh while high
//   last[9:0]  out  most recently captured temperature
// ---------------------------------------------------------------------------
module thermal_sample_timer
   import thermal_guard_pkg::*;
#(
   parameter int unsigned SAMPLE_DIV = 65536
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [9:0] temp,
   output logic       sample_vld,
   output logic [9:0] last
);

   localparam int unsigned      DIV_W    = $clog2(SAMPLE_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

   logic [DIV_W-1:0] div_r;
   logic [9:0]       sync1_r;
   logic [9:0]       sync2_r;
   logic [9:0]       sync3_r;
   logic             req_r;
   logic             vld_r;
   logic [9:0]       last_r;
   logic             term_s;
   logic             stable_s;
   logic             capture_s;

   assign term_s    = (div_r == DIV_LAST);
   assign stable_s  = (sync2_r == sync3_r);
   assign capture_s = req_r & stable_s;

   // Free-running sample-rate divider
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_r <= '0;
      end else if (term_s) begin
         div_r <= '0;
      end else begin
         div_r <= div_r + DIV_W'(1);
      end
   end

   // Synchroniser chain; the third stage only feeds the stability compare
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_r <= 10'd0;
         sync2_r <= 10'd0;
         sync3_r <= 10'd0;
      end else begin
         sync1_r <= temp;
         sync2_r <= sync1_r;
         sync3_r <= sync2_r;
      end
   end

   // Request/capture handshake; a terminal count re-arms even while capturing
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_r  <= 1'b0;
         vld_r  <= 1'b0;
         last_r <= 10'd0;
      end else begin
         vld_r <= capture_s;
         if (capture_s) begin
            last_r <= sync3_r;
         end
         if (term_s) begin
            req_r <= 1'b1;
         end else if (capture_s) begin
            req_r <= 1'b0;
         end
      end
   end

   assign sample_vld = vld_r;
   assign last       = last_r;

endmodule

// File: rtl/sysmon_thermal_guard.sv
// ---------------------------------------------------------------------------
// sysmon_thermal_guard
// Thermal supervisor behind the system monitor. Samples the raw temperature
// at a fixed rate, runs a debounced, hysteretic NORMAL/WARN/ALARM machine
// against programmable thresholds and drives warn/alarm to board logic.
// Thresholds, status and min/max history sit on the PicoBus.
//
// Ports:
//   PicoClk          in   sole clock
//   PicoRst_n        in   asynchronous active-low reset
//   PicoAddr[31:0]   in   bus byte address
//   PicoDataIn[31:0] in   bus write data
//   PicoDataOut[31:0]out  registered read data (valid 1 cycle after PicoRd)
//   PicoRd           in   read strobe
//   PicoWr           in   write strobe
//   temp[9:0]        in   raw temperature from the system monitor (async)
//   warn             out  high in WARN or ALARM
//   alarm            out  high in ALARM
//
// Build option: THERMAL_GUARD_MINMAX_EN enables min/max history at +C.
// ---------------------------------------------------------------------------
`ifndef THERMAL_GUARD_ADDR
`define THERMAL_GUARD_ADDR 32'h0000_0F00
`endif

module sysmon_thermal_guard
   import thermal_guard_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR     = `THERMAL_GUARD_ADDR,
   parameter int unsigned SAMPLE_DIV    = 65536,
   parameter int unsigned DEBOUNCE      = 4,
   parameter logic [9:0]  WARN_DEFAULT  = DEF_WARN_TH,
   parameter logic [9:0]  ALARM_DEFAULT = DEF_ALARM_TH,
   parameter logic [5:0]  HYST_DEFAULT  = DEF_HYST
)(
   input  logic        PicoClk,
   input  logic        PicoRst_n,
   input  logic [31:0] PicoAddr,
   input  logic [31:0] PicoDataIn,
   output logic [31:0] PicoDataOut,
   input  logic        PicoRd,
   input  logic        PicoWr,
   input  logic [9:0]  temp,
   output logic        warn,
   output logic        alarm
);

   localparam logic [3:0] DEB_CNT = 4'(DEBOUNCE);

   logic        sample_vld_s;
   logic [9:0]  last_s;

   logic        hit_status_s, hit_thresh_s, hit_hyst_s, hit_ctrl_s;
   logic        wr_thresh_s, wr_hyst_s, wr_ctrl_s;
   logic [9:0]  warn_th_r, alarm_th_r;
   logic [5:0]  hyst_r;
   logic [9:0]  warn_eff_s, alarm_eff_s;
   logic [5:0]  hyst_eff_s;
   logic [9:0]  warn_rel_s, alarm_rel_s;
   logic        clr_eff_s;

   tg_state_e   state_r, state_next_s;
   logic [3:0]  dbc_r, dbc_next_s, dbc_inc_s;
   logic        clr_pend_r, clr_next_s;

   logic        warn_r, alarm_r;
   logic [31:0] data_out_r;
   logic [31:0] rd_data_s;
   logic [31:0] ctrl_rd_s;
   logic        unused_bits_s;

   thermal_sample_timer #(
      .SAMPLE_DIV (SAMPLE_DIV)
   ) u_timer (
      .clk        (PicoClk),
      .rst_n      (PicoRst_n),
      .temp       (temp),
      .sample_vld (sample_vld_s),
      .last       (last_s)
   );

   assign hit_status_s = (PicoAddr == BASE_ADDR + OFF_STATUS);
   assign hit_thresh_s = (PicoAddr == BASE_ADDR + OFF_THRESH);
   assign hit_hyst_s   = (PicoAddr == BASE_ADDR + OFF_HYST);
   assign hit_ctrl_s   = (PicoAddr == BASE_ADDR + OFF_CTRL);
   assign wr_thresh_s  = PicoWr & hit_thresh_s;
   assign wr_hyst_s    = PicoWr & hit_hyst_s;
   assign wr_ctrl_s    = PicoWr & hit_ctrl_s;

   assign unused_bits_s = ^{PicoDataIn[31:26], PicoDataIn[15:10]};

   // A write landing with sample_vld must already steer that sample
   assign warn_eff_s  = wr_thresh_s ? PicoDataIn[9:0]   : warn_th_r;
   assign alarm_eff_s = wr_thresh_s ? PicoDataIn[25:16] : alarm_th_r;
   assign hyst_eff_s  = wr_hyst_s   ? PicoDataIn[5:0]   : hyst_r;
   assign warn_rel_s  = release_level(warn_eff_s, hyst_eff_s);
   assign alarm_rel_s = release_level(alarm_eff_s, hyst_eff_s);
   assign clr_eff_s   = clr_pend_r |
                        (wr_ctrl_s & PicoDataIn[CLR_BIT] & (state_r == ST_ALARM));
   assign dbc_inc_s   = sat_inc4(dbc_r);

   // Programmable thresholds and hysteresis
   always_ff @(posedge PicoClk or negedge PicoRst_n) begin
      if (!PicoRst_n) begin
         warn_th_r  <= WARN_DEFAULT;
         alarm_th_r <= ALARM_DEFAULT;
         hyst_r     <= HYST_DEFAULT;
      end else begin
         warn_th_r  <= warn_eff_s;
         alarm_th_r <= alarm_eff_s;
         hyst_r     <= hyst_eff_s;
      end
   end

   // Supervisor state, debounce counter and pending clear
   always_ff @(posedge PicoClk or negedge PicoRst_n) begin
      if (!PicoRst_n) begin
         state_r    <= ST_NORMAL;
         dbc_r      <= 4'd0;
         clr_pend_r <= 1'b0;
      end else begin
         state_r    <= state_next_s;
         dbc_r      <= dbc_next_s;
         clr_pend_r <= clr_next_s;
      end
   end

   // Escalation / release decisions, evaluated once per captured sample.
   // The debounce count restarts on every state change so each escalation
   // step needs its own run of DEBOUNCE hot samples.
   always_comb begin
      state_next_s = state_r;
      dbc_next_s   = dbc_r;
      clr_next_s   = clr_eff_s;
      if (sample_vld_s) begin
         case (state_r)
            ST_NORMAL: begin
               if (last_s >= warn_eff_s) begin
                  if (dbc_inc_s == DEB_CNT) begin
                     state_next_s = ST_WARN;
                     dbc_next_s   = 4'd0;
                  end else begin
                     dbc_next_s   = dbc_inc_s;
                  end
               end else begin
                  dbc_next_s = 4'd0;
               end
            end
            ST_WARN: begin
               if (last_s < warn_rel_s) begin
                  state_next_s = ST_NORMAL;
                  dbc_next_s   = 4'd0;
               end else if (last_s >= alarm_eff_s) begin
                  if (dbc_inc_s == DEB_CNT) begin
                     state_next_s = ST_ALARM;
                     dbc_next_s   = 4'd0;
                  end else begin
                     dbc_next_s   = dbc_inc_s;
                  end
               end else begin
                  dbc_next_s = 4'd0;
               end
            end
            ST_ALARM: begin
               if (clr_eff_s && (last_s < alarm_rel_s)) begin
                  state_next_s = (last_s < warn_rel_s) ? ST_NORMAL : ST_WARN;
                  dbc_next_s   = 4'd0;
                  clr_next_s   = 1'b0;
               end else begin
                  dbc_next_s   = dbc_r;
               end
            end
            default: begin
               state_next_s = ST_NORMAL;
               dbc_next_s   = 4'd0;
               clr_next_s   = 1'b0;
            end
         endcase
      end else begin
         dbc_next_s = dbc_r;
      end
   end

`ifdef THERMAL_GUARD_MINMAX_EN
   logic [9:0] min_r, max_r;
   logic       mm_rst_s;

   assign mm_rst_s  = wr_ctrl_s & PicoDataIn[MMRST_BIT];
   assign ctrl_rd_s = {6'd0, max_r, 6'd0, min_r};

   // Min/max history; a reset coinciding with a sample seeds both with it
   always_ff @(posedge PicoClk or negedge PicoRst_n) begin
      if (!PicoRst_n) begin
         min_r <= 10'h3FF;
         max_r <= 10'h000;
      end else if (mm_rst_s) begin
         if (sample_vld_s) begin
            min_r <= last_s;
            max_r <= last_s;
         end else begin
            min_r <= 10'h3FF;
            max_r <= 10'h000;
         end
      end else if (sample_vld_s) begin
         if (last_s < min_r) begin
            min_r <= last_s;
         end
         if (last_s > max_r) begin
            max_r <= last_s;
         end
      end
   end
`else
   assign ctrl_rd_s = 32'h0000_0000;
`endif

   // Read-data decode; unmapped addresses read as zero
   always_comb begin
      rd_data_s = 32'h0000_0000;
      if (hit_status_s) begin
         rd_data_s = {state_r, clr_pend_r, 19'd0, last_s};
      end else if (hit_thresh_s) begin
         rd_data_s = {6'd0, alarm_th_r, 6'd0, warn_th_r};
      end else if (hit_hyst_s) begin
         rd_data_s = {26'd0, hyst_r};
      end else if (hit_ctrl_s) begin
         rd_data_s = ctrl_rd_s;
      end else begin
         rd_data_s = 32'h0000_0000;
      end
   end

   // Registered bus read data and state decodes
   always_ff @(posedge PicoClk or negedge PicoRst_n) begin
      if (!PicoRst_n) begin
         data_out_r <= 32'h0000_0000;
         warn_r     <= 1'b0;
         alarm_r    <= 1'b0;
      end else begin
         if (PicoRd) begin
            data_out_r <= rd_data_s;
         end
         warn_r  <= (state_r != ST_NORMAL);
         alarm_r <= (state_r == ST_ALARM);
      end
   end

   assign PicoDataOut = data_out_r;
   assign warn        = warn_r;
   assign alarm       = alarm_r;

endmodule

// File: doc/sysmon_thermal_guard.md
# sysmon_thermal_guard

Thermal supervisor sitting directly downstream of the system monitor block: consumes its raw 10-bit `temp` output and samples it at a fixed rate. It runs a debounced, hysteretic NORMAL/WARN/ALARM state machine against software-programmable thresholds and drives `warn`/`alarm` to board logic. Thresholds, status and min/max history are exposed on the PicoBus.

## Interface
- `BASE_ADDR`, default `` `THERMAL_GUARD_ADDR `` (PicoDefines.v): byte base of the 4-word register window.
- `SAMPLE_DIV`, default 65536: PicoClk cycles between sample requests (≥4).
- `DEBOUNCE`, default 4: consecutive over-threshold samples needed to escalate (1–15).
- `WARN_DEFAULT`, default 10'h2C3: reset warn threshold (~75 °C).
- `ALARM_DEFAULT`, default 10'h2EC: reset alarm threshold (~95 °C).
- `HYST_DEFAULT`, default 6'd8: reset hysteresis in raw LSB (~4 °C).
- `PicoClk` in 1: sole clock.
- `PicoRst_n` in 1: reset, asynchronous, active-low.
- `PicoAddr` in 32: bus byte address.
- `PicoDataIn` in 32: bus write data.
- `PicoDataOut` out 32: registered read data.
- `PicoRd` in 1: read strobe.
- `PicoWr` in 1: write strobe.
- `temp` in 10: raw temperature from the system monitor. It updates on a divided clock and is treated as asynchronous.
- `warn` out 1: high in WARN or ALARM.
- `alarm` out 1: high in ALARM.

## Operation
- `temp` is double-synchronised, then passed through a third stage. A value is *stable* when stage2 == stage3.
- The divider counts 0..SAMPLE_DIV-1. At terminal count it sets `sample_req`.
- While `sample_req` is set, the first stable cycle captures `last`, pulses `sample_vld` and clears `sample_req`.
- Per `sample_vld`, comparisons are unsigned 10-bit. Release levels are `thr - hyst`, saturating at 0.
  - NORMAL: if `last ≥ warn_th`, increment `dbc`, else clear `dbc`. At `dbc == DEBOUNCE` → WARN, and `dbc` clears.
  - WARN: if `last < warn_th - hyst` → NORMAL. Otherwise, if `last ≥ alarm_th`, increment `dbc`, else clear `dbc`. At `dbc == DEBOUNCE` → ALARM.
  - ALARM: sticky. It is left only when `clr_pend` is set and `last < alarm_th - hyst`.
    - Destination is NORMAL if `last < warn_th - hyst`, else WARN.
    - `clr_pend` clears on exit. A sample that is still hot keeps ALARM and retains `clr_pend`.
- `dbc` is 4 bits and saturates.
- Registers, by offset from BASE_ADDR:
  - +0 R: [31:30] state (0 NORMAL, 1 WARN, 2 ALARM), [29] `clr_pend`, [9:0] `last`.
  - +4 RW: [25:16] `alarm_th`, [9:0] `warn_th`.
  - +8 RW: [5:0] `hyst`.
  - +C W: bit0 sets `clr_pend` (ignored unless in ALARM); bit1 resets min/max. R: [25:16] `max`, [9:0] `min`.
- Unused read bits are 0. Reads of unmapped addresses return 32'h0. Writes to unmapped addresses are ignored.
- The block does not check `warn_th > alarm_th`. Behaviour follows the rules above literally.

## Timing
- Reset values:
  - `PicoDataOut` 0, `warn`/`alarm` 0, state NORMAL.
  - `last` 0, `min` 10'h3FF, `max` 0, `dbc` 0, divider 0, `sample_req` 0, `clr_pend` 0.
  - Thresholds and `hyst` reset to their *_DEFAULT parameters.
- `PicoDataOut` is valid 1 cycle after `PicoRd` with a matching address.
- Latency from a change on `temp` to a captured `last` is at least 3 cycles. It is extended while the value is unstable.
- State updates on the cycle after `sample_vld`. `warn`/`alarm` are registered decodes of state, so they follow 1 cycle later.
- A threshold or hysteresis write takes effect at the next `sample_vld`, including one in the same cycle as the write.
- A clear write coincident with `sample_vld`: the clear applies to that sample's evaluation.
- A min/max reset coincident with `sample_vld`: `min = max = last`.
- Reset asserted mid-operation returns every register to its reset value immediately. Programmed thresholds are lost.

## Configuration
- `THERMAL_GUARD_MINMAX_EN` defined: `min`/`max` track every captured sample, and offset +C reads as described.
- Not defined: no min/max storage. +C reads 32'h0, and bit1 writes are ignored.

## Structure
- Package `thermal_guard_pkg`:
  - state encoding (NORMAL/WARN/ALARM)
  - register offsets (0x0/0x4/0x8/0xC)
  - clear and min/max-reset bit positions
  - the three default constants
- Sub-module `thermal_sample_timer`: divider, synchroniser, stability filter and `sample_req` logic. Outputs `sample_vld` and `last[9:0]`.
- The top level holds the FSM, the register file and min/max.

## Test plan
Bench parameters: SAMPLE_DIV=16, DEBOUNCE=4, MINMAX enabled.
- Reset, then read +4 and +8 → 32'h02EC_02C3 and 32'h8; `warn`=`alarm`=0.
- Hold `temp`=10'h2D0 → `warn` rises after the 4th sample; 3 samples at 0x2D0 followed by 1 at 0x2C0 keeps NORMAL.
- In WARN, `temp`=10'h2BC (≥ 0x2C3-8) → stays WARN; `temp`=10'h2BA → NORMAL on the next sample.
- Drive 10'h2F0 to reach ALARM, then write +C=1 while `temp` is still 0x2F0 → ALARM held, +0 bit29=1. Drop to 10'h2C8 → WARN. Drop to 10'h2B0 → NORMAL.
- Toggle `temp` every cycle between 0x100 and 0x200 around a sample request → no capture until the value is held for 2 cycles, then `last` equals the held value.
- Samples 0x150, 0x2A0, 0x120 → +C reads 32'h02A0_0120. Write +C=2 coincident with a sample of 0x180 → 32'h0180_0180.
